// File: rtl/disp_arbiter_if.sv
// Request/display bus between three display requesters and the display arbiter.
interface disp_arbiter_if;
  logic [2:0]  req;
  logic [2:0]  blink;
  logic [15:0] bcd_in0;
  logic [15:0] bcd_in1;
  logic [15:0] bcd_in2;
  logic [2:0]  grant;
  logic [15:0] bcd_int;
  logic        disp_blank;
  logic        busy;

  modport master (
    output req, blink, bcd_in0, bcd_in1, bcd_in2,
    input  grant, bcd_int, disp_blank, busy
  );

  modport slave (
    input  req, blink, bcd_in0, bcd_in1, bcd_in2,
    output grant, bcd_int, disp_blank, busy
  );
endinterface

// File: rtl/disp_arbiter.sv
// Round-robin arbiter sharing one 4-digit BCD display among three requesters,
// with a minimum hold time and per-owner blinking, both paced by a 1 kHz tick.
module disp_arbiter #(
  parameter int unsigned HOLD_TICKS  = 500,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic           fpga_clk,
  input  logic           sys_rst_n,
  input  logic           clk_1KHz,
  disp_arbiter_if.slave  bus
);

  localparam int unsigned CNT_W = 10;

  typedef enum logic [1:0] {IDLE, HOLD, OPEN} state_t;

  state_t             state_q;
  logic [2:0]         grant_q;
  logic [1:0]         ptr_q;
  logic [CNT_W-1:0]   hold_q;
  logic [CNT_W-1:0]   blink_cnt_q;
  logic               blank_q;
  logic               blink_prev_q;
  logic               busy_q;
  logic [15:0]        bcd_q;
  logic               s1_q, s2_q, s3_q;
  logic [1:0]         arm_q;
  logic               armed_q;

  logic               tick_c;
  logic               owner_req_c;
  logic               owner_blink_c;
  logic [2:0]         pick_mask_c;
  logic [1:0]         win_idx_c;
  logic [2:0]         win_oh_c;
  logic               regrant_c;
  logic [15:0]        bcd_sel_c;

  // Search order ptr+1, ptr+2, ptr: the last match in this loop wins.
  function automatic logic [1:0] rr_pick(input logic [2:0] mask, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(ptr) + k) % 3);
      if (mask[idx]) rr_pick = idx;
    end
  endfunction

  // Tick is held off until the sync pipe has seen clk_1KHz low after reset.
  assign tick_c        = s2_q & ~s3_q & armed_q;
  assign owner_req_c   = |(bus.req & grant_q);
  assign owner_blink_c = |(bus.blink & grant_q);
  assign pick_mask_c   = (state_q == IDLE) ? bus.req : (bus.req & ~grant_q);
  assign win_idx_c     = rr_pick(pick_mask_c, ptr_q);
  assign win_oh_c      = 3'(3'b001 << win_idx_c);
  assign regrant_c     = (state_q == IDLE) ? (|bus.req)
                                           : ((state_q == OPEN) && owner_req_c && (|pick_mask_c));
  assign bcd_sel_c     = grant_q[0] ? bus.bcd_in0 :
                         grant_q[1] ? bus.bcd_in1 :
                         grant_q[2] ? bus.bcd_in2 : 16'h0000;

  always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 3'b000;
      ptr_q        <= 2'd2;
      hold_q       <= '0;
      blink_cnt_q  <= '0;
      blank_q      <= 1'b1;
      blink_prev_q <= 1'b0;
      busy_q       <= 1'b0;
      bcd_q        <= 16'h0000;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      arm_q        <= 2'b00;
      armed_q      <= 1'b0;
    end else begin
      s1_q    <= clk_1KHz;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      arm_q   <= {arm_q[0], 1'b1};
      armed_q <= armed_q | (arm_q[1] & ~s2_q);
      bcd_q   <= bcd_sel_c;

      if ((state_q != IDLE) && !owner_req_c) begin
        // Owner release beats every other event.
        state_q      <= IDLE;
        grant_q      <= 3'b000;
        busy_q       <= 1'b0;
        blank_q      <= 1'b1;
        bcd_q        <= 16'h0000;
        blink_prev_q <= 1'b0;
      end else if (regrant_c) begin
        state_q      <= HOLD;
        grant_q      <= win_oh_c;
        ptr_q        <= win_idx_c;
        busy_q       <= 1'b1;
        hold_q       <= CNT_W'(HOLD_TICKS);
        blink_cnt_q  <= CNT_W'(BLINK_TICKS);
        blank_q      <= 1'b0;
        blink_prev_q <= |(bus.blink & win_oh_c);
      end else if (state_q != IDLE) begin
        if (state_q == HOLD) begin
          if (hold_q == '0) begin
            state_q <= OPEN;
          end else if (tick_c) begin
            hold_q <= hold_q - CNT_W'(1);
          end
        end
        blink_prev_q <= owner_blink_c;
        if (!owner_blink_c) begin
          blank_q <= 1'b0;
        end else if (!blink_prev_q) begin
          blank_q     <= 1'b0;
          blink_cnt_q <= CNT_W'(BLINK_TICKS);
        end else if (tick_c) begin
          if (blink_cnt_q <= CNT_W'(1)) begin
            blank_q     <= ~blank_q;
            blink_cnt_q <= CNT_W'(BLINK_TICKS);
          end else begin
            blink_cnt_q <= blink_cnt_q - CNT_W'(1);
          end
        end
      end
    end
  end

  assign bus.grant      = grant_q;
  assign bus.bcd_int    = bcd_q;
  assign bus.disp_blank = blank_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/disp_arbiter.md
DISP_ARBITER -- requirements
Module: disp_arbiter

Interface
REQ-001: Parameter HOLD_TICKS, default 500, minimum number of 1 kHz ticks a grant is held before it can be preempted; legal range 1..1023.
REQ-002: Parameter BLINK_TICKS, default 250, number of 1 kHz ticks per blink half-period; legal range 1..1023.
REQ-003: fpga_clk  input  1  system clock; all state changes on the rising edge.
REQ-004: sys_rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005: clk_1KHz  input  1  free-running 1 kHz square wave, asynchronous to fpga_clk.
REQ-006: req  input  3  per-requester display request; bit i is requester i.
REQ-007: blink  input  3  per-requester blink enable; sampled only for the current owner.
REQ-008: bcd_in0, bcd_in1, bcd_in2  input  16 each  4-digit BCD value of requester 0/1/2.
REQ-009: grant  output  3  one-hot current owner; 000 when idle.
REQ-010: bcd_int  output  16  BCD value for the 4-digit display multiplexer.
REQ-011: disp_blank  output  1  1 = display blanked.
REQ-012: busy  output  1  1 whenever grant is non-zero.

Function
REQ-013: The block SHALL double-register clk_1KHz and generate a one-cycle tick on every 0->1 transition of the second stage; tick is asserted on the 3rd fpga_clk edge after the input rises (within setup margin).
REQ-014: The FSM SHALL have states IDLE, HOLD and OPEN.
REQ-015: IDLE: grant=000, disp_blank=1, bcd_int=0; if any req bit is set, select the winner round-robin and go to HOLD, with grant registered on that same edge.
REQ-016: Round-robin search order SHALL be ptr+1, ptr+2, ptr (mod 3), where ptr is the index of the last owner; on each grant ptr is updated to the winner.
REQ-017: On entry to HOLD, the hold counter SHALL load HOLD_TICKS; it decrements by 1 per tick; a tick on the load cycle is ignored.
REQ-018: HOLD: requests from non-owners SHALL be ignored; when the counter reaches 0, go to OPEN.
REQ-019: OPEN: if any non-owner req is set, grant the next requester in round-robin order and re-enter HOLD directly with no idle cycle.
REQ-020: In HOLD or OPEN, owner req deassertion SHALL take precedence over every other event: go to IDLE for exactly one cycle, then re-arbitrate.
REQ-021: bcd_int SHALL equal the owner's bcd_inN, registered with one cycle of latency after grant; it is 0 in IDLE.
REQ-022: disp_blank SHALL be 0 when an owner exists and that owner's blink bit is 0.
REQ-023: When the owner's blink bit is 1, disp_blank SHALL toggle every BLINK_TICKS ticks.
REQ-024: The blink phase SHALL restart (display on, counter reloaded with BLINK_TICKS) on every grant change and on every 0->1 transition of the owner's blink bit.
REQ-025: The hold and blink counters SHALL be 10 bits wide, SHALL never underflow, and SHALL saturate at 0.
REQ-026: grant SHALL never have more than one bit set.
REQ-027: busy SHALL be a registered copy of the state that matches the grant timing.

Reset
REQ-028: While sys_rst_n=0 the block SHALL hold: state=IDLE, grant=000, bcd_int=0, disp_blank=1, busy=0, ptr=2 (requester 0 wins first), counters=0, sync/edge registers=0.
REQ-029: Assertion mid-operation SHALL take effect immediately (asynchronously).
REQ-030: After release, the block SHALL operate from the first fpga_clk edge, and no spurious tick SHALL be generated if clk_1KHz is already high at release.

Verification
REQ-031: Reset asserted during HOLD with grant=010 -> grant=000, bcd_int=0, disp_blank=1 immediately, with no clock required.
REQ-032: req=001, bcd_in0=0x1234 -> grant=001 one edge later and bcd_int=0x1234 one further edge later, disp_blank=0.
REQ-033: Owner 0 held, req1 raised after 10 ticks -> grant stays 001 until tick 500, then 010 with no blank cycle.
REQ-034: req=111 throughout, each owner drops its req for a single cycle when granted -> grant sequence 001, 010, 100, 001, each separated by one IDLE cycle.
REQ-035: Owner 0 with blink0=1 -> disp_blank goes 0 for 250 ticks, 1 for 250 ticks, repeating; the phase restarts at 0 when the grant changes.
REQ-036: clk_1KHz high at reset release -> no tick and no hold decrement until the next rising edge.
